// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer: start, data LSB first, optional parity, stop
module uart_tx_serializer #(
    parameter int WORD_LENGHT = 8,
    parameter int FREQUENCY   = 50000000,
    parameter int BAUDRATE    = 9600,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGHT-1:0] TX_in,
    input  logic                   send,
    output logic                   TX_out,
    output logic                   busy,
    output logic                   done
);

    localparam int BAUD_DIV = FREQUENCY / BAUDRATE;
    localparam int BAUD_W   = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W    = $clog2(WORD_LENGHT + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_LENGHT - 1);
    localparam logic              ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state, state_next;
    logic [BAUD_W-1:0]      baud_cnt, baud_next;
    logic [BIT_W-1:0]       bit_cnt, bit_next;
    logic [WORD_LENGHT-1:0] shreg, shreg_next;
    logic                   parity_bit, parity_next;
    logic                   line_q, line_next;
    logic                   bit_end;

    // State and datapath registers; the line is registered from the next
    // state so it falls on the same edge that accepts a request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            line_q     <= 1'b1;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_cnt    <= bit_next;
            shreg      <= shreg_next;
            parity_bit <= parity_next;
            line_q     <= line_next;
        end
    end

    // Next-state, counter and shift-register update, plus next line level.
    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt + 1'b1;
        bit_next    = bit_cnt;
        shreg_next  = shreg;
        parity_next = parity_bit;
        line_next   = 1'b1;
        bit_end     = (baud_cnt == BAUD_LAST);

        case (state)
            S_IDLE: begin
                baud_next = '0;
                if (send) begin
                    shreg_next = TX_in;
                    if (PARITY_EN != 0) begin
                        parity_next = (^TX_in) ^ ODD_BIT;
                    end
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shreg_next = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Every bit period starts from a cleared baud counter.
        if (state_next != state) begin
            baud_next = '0;
        end

        case (state_next)
            S_START:  line_next = 1'b0;
            S_DATA:   line_next = shreg_next[0];
            S_PARITY: line_next = parity_next;
            default:  line_next = 1'b1;
        endcase
    end

    assign TX_out = line_q;
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_STOP) && bit_end;

endmodule
